// File: rtl/player_anim_pkg.sv
// rtl/player_anim_pkg.sv - shared player animation encodings and constants
//
// Purpose: animation state encodings, sprite size, per-state frame counts,
// attack hitbox window and hit-stun duration. The sprite mapper imports the
// same encodings so state numbers stay consistent between logic and art.
// Ports: none (package).
package player_anim_pkg;

  // 2 and 4 are reserved (attack-2 / jump slots in the sprite sheet).
  typedef enum logic [3:0] {
    S_IDLE = 4'd0,
    S_MOVE = 4'd1,
    S_ATK1 = 4'd3,
    S_HIT  = 4'd5
  } anim_state_e;

  localparam int SPR_W = 126;
  localparam int SPR_H = 126;

  localparam logic [5:0] IDLE_FRAMES = 6'd10;
  localparam logic [5:0] MOVE_FRAMES = 6'd8;
  localparam logic [5:0] ATK1_FRAMES = 6'd18;

  localparam logic [5:0] ATK_WIN_FIRST = 6'd7;
  localparam logic [5:0] ATK_WIN_LAST  = 6'd11;

  localparam int HIT_TICKS = 12;

  // HIT shows a single held frame.
  function automatic logic [5:0] frames_of(anim_state_e s);
    case (s)
      S_IDLE:  return IDLE_FRAMES;
      S_MOVE:  return MOVE_FRAMES;
      S_ATK1:  return ATK1_FRAMES;
      default: return 6'd1;
    endcase
  endfunction

  function automatic logic in_attack_window(logic [5:0] f);
    return (f >= ATK_WIN_FIRST) && (f <= ATK_WIN_LAST);
  endfunction

endpackage

// File: rtl/anim_frame_counter.sv
// rtl/anim_frame_counter.sv - frame_tick divider plus wrapping/saturating frame counter
//
// Purpose: divides frame_tick by TICKS_PER_FRAME and steps an animation frame
// index; at the last frame it wraps to 0 (wrap_i=1) or holds (wrap_i=0).
// Ports:
//   clk, rst        clock, synchronous active-high reset
//   clr_i           zero divider and frame (state change); wins over tick_i
//   tick_i          frame_tick pulse
//   wrap_i          1 = wrap at last frame, 0 = saturate
//   n_frames_i      number of frames in the current sequence
//   frame_o         registered frame index
//   frame_nxt_o     frame index the register will take at the next edge
//   adv_o           divider expiry this cycle (frame advance pulse)
//   last_o          frame_o is the last frame of the sequence
module anim_frame_counter #(
  parameter int TICKS_PER_FRAME = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       clr_i,
  input  logic       tick_i,
  input  logic       wrap_i,
  input  logic [5:0] n_frames_i,
  output logic [5:0] frame_o,
  output logic [5:0] frame_nxt_o,
  output logic       adv_o,
  output logic       last_o
);

  localparam int CW = (TICKS_PER_FRAME > 1) ? $clog2(TICKS_PER_FRAME) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(TICKS_PER_FRAME - 1);

  logic [CW-1:0] cnt_q, cnt_d;
  logic [5:0]    frame_q, frame_d;

  assign adv_o  = tick_i && (cnt_q == CNT_LAST);
  assign last_o = (frame_q == (n_frames_i - 6'd1));

  always_comb begin
    cnt_d   = cnt_q;
    frame_d = frame_q;
    if (clr_i) begin
      cnt_d   = '0;
      frame_d = '0;
    end else if (tick_i) begin
      cnt_d = (cnt_q == CNT_LAST) ? '0 : cnt_q + CW'(1);
      if (adv_o) begin
        if (!last_o) begin
          frame_d = frame_q + 6'd1;
        end else if (wrap_i) begin
          frame_d = '0;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q   <= '0;
      frame_q <= '0;
    end else begin
      cnt_q   <= cnt_d;
      frame_q <= frame_d;
    end
  end

  assign frame_o     = frame_q;
  assign frame_nxt_o = frame_d;

endmodule

// File: rtl/player_state_anim.sv
// rtl/player_state_anim.sv - player animation state machine, movement and attack timing
//
// Purpose: IDLE/MOVE/ATK1(/HIT) state machine stepped by frame_tick, with
// horizontal movement clamped to [X_MIN, X_MAX], attack request latch and a
// registered hitbox flag. Optional macro HIT_STUN_EN enables the HIT state.
// Ports:
//   clk, rst              clock, synchronous active-high reset
//   frame_tick            one-cycle pulse per video frame
//   btn_left, btn_right   held direction levels
//   btn_atk               attack button level, rising edge requests attack
//   hit                   one-cycle pulse, player struck (HIT_STUN_EN only)
//   anim_state            S_IDLE/S_MOVE/S_ATK1/S_HIT encoding
//   anim_frame            frame index within the state
//   facing_right          1 = right
//   pos_x, pos_y          sprite top-left in pixels
//   attack_active         hitbox live
//   busy                  in ATK1 or HIT
module player_state_anim
  import player_anim_pkg::*;
#(
  parameter int TICKS_PER_FRAME = 4,
  parameter int MOVE_STEP       = 2,
  parameter int X_MIN           = 0,
  parameter int X_MAX           = 514,
  parameter int START_X         = 100,
  parameter int GROUND_Y        = 300
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       frame_tick,
  input  logic       btn_left,
  input  logic       btn_right,
  input  logic       btn_atk,
  input  logic       hit,
  output logic [3:0] anim_state,
  output logic [5:0] anim_frame,
  output logic       facing_right,
  output logic [9:0] pos_x,
  output logic [9:0] pos_y,
  output logic       attack_active,
  output logic       busy
);

  localparam logic signed [10:0] STEP_S = 11'(MOVE_STEP);
  localparam logic signed [10:0] XMIN_S = 11'(X_MIN);
  localparam logic signed [10:0] XMAX_S = 11'(X_MAX);

  anim_state_e state_q, state_d;
  logic        facing_q, facing_d;
  logic [9:0]  pos_q, pos_d;
  logic        req_q, req_d;
  logic        atk_prev_q;
  logic        busy_q, atk_act_q;

  logic        atk_edge, pending, one_dir;
  logic signed [10:0] pos_s, pos_n;
  logic        clr, adv, last;
  logic [5:0]  frame, frame_nxt;

`ifdef HIT_STUN_EN
  logic [3:0]  hit_cnt_q, hit_cnt_d;
`else
  logic        unused_hit;
  assign unused_hit = hit;
`endif

  anim_frame_counter #(
    .TICKS_PER_FRAME(TICKS_PER_FRAME)
  ) u_frame_cnt (
    .clk        (clk),
    .rst        (rst),
    .clr_i      (clr),
    .tick_i     (frame_tick),
    .wrap_i     (state_q != S_ATK1),
    .n_frames_i (frames_of(state_q)),
    .frame_o    (frame),
    .frame_nxt_o(frame_nxt),
    .adv_o      (adv),
    .last_o     (last)
  );

  always_comb begin
    state_d  = state_q;
    facing_d = facing_q;
    pos_d    = pos_q;
`ifdef HIT_STUN_EN
    hit_cnt_d = hit_cnt_q;
`endif

    // An edge arriving in the tick cycle itself is honoured by that tick.
    atk_edge = btn_atk & ~atk_prev_q;
    pending  = req_q | atk_edge;
    one_dir  = btn_left ^ btn_right;

    // Widened signed arithmetic so a step below X_MIN cannot wrap around.
    pos_s = $signed({1'b0, pos_q});
    if (btn_right) begin
      pos_n = pos_s + STEP_S;
      if (pos_n > XMAX_S) pos_n = XMAX_S;
    end else begin
      pos_n = pos_s - STEP_S;
      if (pos_n < XMIN_S) pos_n = XMIN_S;
    end

    // Requests are only held while a tick could still consume them; any
    // tick in IDLE/MOVE either consumes the request or had none pending.
    case (state_q)
      S_IDLE, S_MOVE: req_d = frame_tick ? 1'b0 : pending;
      default:        req_d = 1'b0;
    endcase

    if (frame_tick) begin
      case (state_q)
        S_IDLE: begin
          if (pending) begin
            state_d = S_ATK1;
          end else if (one_dir) begin
            // The entry tick already moves, so a held button moves every tick.
            state_d  = S_MOVE;
            facing_d = btn_right;
            pos_d    = pos_n[9:0];
          end
        end
        S_MOVE: begin
          if (pending) begin
            state_d = S_ATK1;
          end else if (!one_dir) begin
            state_d = S_IDLE;
          end else begin
            facing_d = btn_right;
            pos_d    = pos_n[9:0];
          end
        end
        S_ATK1: begin
          if (adv && last) state_d = S_IDLE;
        end
`ifdef HIT_STUN_EN
        S_HIT: begin
          if (hit_cnt_q == 4'(HIT_TICKS - 1)) begin
            state_d   = S_IDLE;
            hit_cnt_d = '0;
          end else begin
            hit_cnt_d = hit_cnt_q + 4'd1;
          end
        end
`endif
        default: state_d = S_IDLE;
      endcase
    end

`ifdef HIT_STUN_EN
    // A hit pre-empts everything, including the tick of this same cycle.
    if (hit) begin
      state_d   = S_HIT;
      facing_d  = facing_q;
      pos_d     = pos_q;
      req_d     = 1'b0;
      hit_cnt_d = '0;
    end
`endif

    // HIT pins the frame at 0; re-entering HIT also restarts the divider.
    clr = (state_d != state_q) || (state_d == S_HIT);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= S_IDLE;
      facing_q   <= 1'b1;
      pos_q      <= 10'(START_X);
      req_q      <= 1'b0;
      atk_prev_q <= 1'b0;
      busy_q     <= 1'b0;
      atk_act_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      facing_q   <= facing_d;
      pos_q      <= pos_d;
      req_q      <= req_d;
      atk_prev_q <= btn_atk;
      busy_q     <= (state_d == S_ATK1) || (state_d == S_HIT);
      atk_act_q  <= (state_d == S_ATK1) && in_attack_window(frame_nxt);
    end
  end

`ifdef HIT_STUN_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      hit_cnt_q <= '0;
    end else begin
      hit_cnt_q <= hit_cnt_d;
    end
  end
`endif

  assign anim_state    = state_q;
  assign anim_frame    = frame;
  assign facing_right  = facing_q;
  assign pos_x         = pos_q;
  assign pos_y         = 10'(GROUND_Y);
  assign attack_active = atk_act_q;
  assign busy          = busy_q;

endmodule

// File: tb/tb_player_state_anim.sv
// tb/tb_player_state_anim.sv - self-checking bench for player_state_anim
module tb_player_state_anim;

  logic       clk = 1'b0;
  logic       rst, frame_tick, btn_left, btn_right, btn_atk, hit;
  logic [3:0] anim_state;
  logic [5:0] anim_frame;
  logic       facing_right;
  logic [9:0] pos_x, pos_y;
  logic       attack_active, busy;

  player_state_anim dut (
    .clk          (clk),
    .rst          (rst),
    .frame_tick   (frame_tick),
    .btn_left     (btn_left),
    .btn_right    (btn_right),
    .btn_atk      (btn_atk),
    .hit          (hit),
    .anim_state   (anim_state),
    .anim_frame   (anim_frame),
    .facing_right (facing_right),
    .pos_x        (pos_x),
    .pos_y        (pos_y),
    .attack_active(attack_active),
    .busy         (busy)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model: state plus number of ticks spent in that state.
  int m_st, m_tis, m_pos, m_face, m_req, m_prev;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  function automatic int m_frame();
    case (m_st)
      0:       return (m_tis / 4) % 10;
      1:       return (m_tis / 4) % 8;
      3:       return m_tis / 4;
      default: return 0;
    endcase
  endfunction

  function automatic void m_enter(input int s);
    m_st  = s;
    m_tis = 0;
  endfunction

  function automatic void m_move();
    if (btn_right) m_pos = (m_pos + 2 > 514) ? 514 : m_pos + 2;
    else           m_pos = (m_pos - 2 < 0)   ? 0   : m_pos - 2;
    m_face = btn_right;
  endfunction

  task automatic model_step();
    int edge_v, pend, old;
    edge_v = (btn_atk && !m_prev) ? 1 : 0;
    m_prev = btn_atk;
    if (rst) begin
      m_st = 0; m_tis = 0; m_pos = 100; m_face = 1; m_req = 0; m_prev = 0;
      return;
    end
    old = m_st;
`ifdef HIT_STUN_EN
    if (hit) begin
      m_enter(5);
      m_req = 0;
      return;
    end
`endif
    pend = (m_req != 0 || edge_v != 0) ? 1 : 0;
    if (frame_tick) begin
      case (old)
        0: if (pend != 0) m_enter(3);
           else if (btn_left != btn_right) begin m_enter(1); m_move(); end
           else m_tis++;
        1: if (pend != 0) m_enter(3);
           else if (btn_left == btn_right) m_enter(0);
           else begin m_move(); m_tis++; end
        3: begin m_tis++; if (m_tis == 72) m_enter(0); end
        5: begin m_tis++; if (m_tis == 12) m_enter(0); end
        default: ;
      endcase
    end
    m_req = ((old == 0 || old == 1) && !frame_tick) ? pend : 0;
  endtask

  task automatic check_all();
    int f;
    f = m_frame();
    check("state",  anim_state,    m_st);
    check("frame",  anim_frame,    f);
    check("facing", facing_right,  m_face);
    check("pos_x",  pos_x,         m_pos);
    check("pos_y",  pos_y,         300);
    check("atk",    attack_active, (m_st == 3 && f >= 7 && f <= 11) ? 1 : 0);
    check("busy",   busy,          (m_st == 3 || m_st == 5) ? 1 : 0);
  endtask

  task automatic cycle();
    @(posedge clk);
    model_step();
    #1;
    check_all();
  endtask

  task automatic tick_n(input int n);
    for (int i = 0; i < n; i++) begin
      frame_tick = 1'b1;
      cycle();
      frame_tick = 1'b0;
      cycle();
    end
  endtask

  task automatic atk_pulse();
    btn_atk = 1'b1;
    cycle();
    btn_atk = 1'b0;
    cycle();
  endtask

  initial begin
    int act;
    rst = 1'b1; frame_tick = 1'b0; btn_left = 1'b0; btn_right = 1'b0;
    btn_atk = 1'b0; hit = 1'b0;
    m_st = 0; m_tis = 0; m_pos = 100; m_face = 1; m_req = 0; m_prev = 0;

    cycle();
    cycle();
    check("rst_state", anim_state, 0);
    check("rst_pos",   pos_x, 100);
    check("rst_face",  facing_right, 1);
    rst = 1'b0;

    // idle animation: frame advances every 4 ticks
    tick_n(25);
    check("idle_frame", anim_frame, 6);
    check("idle_pos",   pos_x, 100);

    // move left 10 ticks, then run into the left clamp
    btn_left = 1'b1;
    tick_n(10);
    check("left_pos",   pos_x, 80);
    check("left_face",  facing_right, 0);
    check("left_state", anim_state, 1);
    tick_n(45);
    check("clamp_lo", pos_x, 0);
    btn_left = 1'b0;

    // both held while moving -> idle, position kept
    btn_right = 1'b1;
    tick_n(3);
    check("right_pos", pos_x, 6);
    btn_left = 1'b1;
    tick_n(1);
    check("both_state", anim_state, 0);
    check("both_pos",   pos_x, 6);
    btn_left = 1'b0; btn_right = 1'b0;

    // full attack; second press mid-attack is discarded
    atk_pulse();
    tick_n(1);
    check("atk_enter", anim_state, 3);
    act = 0;
    for (int k = 1; k <= 72; k++) begin
      frame_tick = 1'b1;
      cycle();
      frame_tick = 1'b0;
      if (attack_active) act++;
      if (k == 30) btn_atk = 1'b1;
      cycle();
      btn_atk = 1'b0;
    end
    check("atk_ticks",  act, 20);
    check("atk_exit",   anim_state, 0);
    check("atk_exit_f", anim_frame, 0);
    tick_n(2);
    check("atk_no_repeat", anim_state, 0);

    // reset coincident with a tick mid-attack
    atk_pulse();
    tick_n(21);
    check("pre_rst_frame", anim_frame, 5);
    rst = 1'b1; frame_tick = 1'b1;
    cycle();
    rst = 1'b0; frame_tick = 1'b0;
    check("mid_rst_state", anim_state, 0);
    check("mid_rst_frame", anim_frame, 0);
    check("mid_rst_busy",  busy, 0);
    check("mid_rst_pos",   pos_x, 100);

    // hit at attack frame 9
    atk_pulse();
    tick_n(37);
    check("pre_hit_frame", anim_frame, 9);
    hit = 1'b1;
    cycle();
    hit = 1'b0;
`ifdef HIT_STUN_EN
    check("hit_state", anim_state, 5);
    check("hit_atk",   attack_active, 0);
    check("hit_busy",  busy, 1);
    tick_n(11);
    check("hit_hold", busy, 1);
    tick_n(1);
    check("hit_exit", anim_state, 0);
`else
    check("nohit_state", anim_state, 3);
    check("nohit_frame", anim_frame, 9);
`endif
    tick_n(80);

    // right clamp
    btn_right = 1'b1;
    tick_n(260);
    check("clamp_hi", pos_x, 514);
    btn_right = 1'b0;

    // randomized traffic against the model
    for (int i = 0; i < 3000; i++) begin
      frame_tick = ($urandom_range(2) == 0);
      if ($urandom_range(15) == 0) begin
        btn_left  = $urandom_range(1);
        btn_right = $urandom_range(1);
      end
      if ($urandom_range(7) == 0) btn_atk = $urandom_range(1);
      hit = ($urandom_range(149) == 0);
      rst = ($urandom_range(499) == 0);
      cycle();
    end
    rst = 1'b0; hit = 1'b0;

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
